// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants: the word type, the bubble encoding,
// fetch FSM states and the IF/ID payload.
package mips_pkg;
  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR_C  = 32'h0000_0000;  // sll $0,$0,0
  localparam word_t RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_e;

  typedef struct packed {
    word_t instr;
    word_t pc_plus4;
    logic  valid;
  } ifid_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage and imem.
interface fetch_unit_if;
  import mips_pkg::*;
  logic  ImemReq;
  word_t ImemAddr;
  word_t ImemRdata;
  logic  ImemReady;

  modport master (output ImemReq, ImemAddr, input ImemRdata, ImemReady);
  modport slave  (input ImemReq, ImemAddr, output ImemRdata, ImemReady);
endinterface

// File: rtl/if_id_reg.sv
// Pipeline register with hold enable and synchronous bubble load; payload type
// is a parameter so the same block serves ID/EX with a flush.
module if_id_reg
  import mips_pkg::*;
#(
  parameter type T      = ifid_t,
  parameter T    BUBBLE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bubble,
  input  T     d,
  output T     q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= BUBBLE;
    else if (en)  q <= bubble ? BUBBLE : d;
  end
endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, imem request/ready handshake and
// the IF/ID register. Memory latency turns into decode bubbles, not stalls.
module fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   StallF,
  input  logic   StallD,
  input  logic   PCSrcD,
  input  word_t  PCBranchD,
  fetch_unit_if.master imem,
  output word_t  InstrD,
  output word_t  PCPlus4D,
  output logic   ValidD
);
  localparam ifid_t BUBBLE_V = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  fetch_state_e state;
  word_t        pcf, buffer, redir_pc;
  logic         req;

  logic  redir;
  word_t target, pc_plus4;
  ifid_t ifid_d, ifid_q;
  logic  ifid_bubble;

  assign redir    = PCSrcD & ~StallD;
  assign target   = {PCBranchD[31:2], 2'b00};
  assign pc_plus4 = pcf + 32'd4;

  assign imem.ImemAddr = pcf;
  assign imem.ImemReq  = req;

  // Only a completed, non-redirected, unstalled fetch (or a HOLD release) is real.
  always_comb begin
    ifid_bubble = 1'b1;
    ifid_d      = '{instr: imem.ImemRdata, pc_plus4: pc_plus4, valid: 1'b1};
    case (state)
      FETCH: if (imem.ImemReady && !redir && !StallF) ifid_bubble = 1'b0;
      HOLD: if (!redir && !StallF) begin
        ifid_bubble  = 1'b0;
        ifid_d.instr = buffer;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pcf      <= RESET_PC;
      buffer   <= '0;
      redir_pc <= '0;
      req      <= 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (imem.ImemReady) begin
            if (redir) pcf <= target;
            else if (StallF) begin
              buffer <= imem.ImemRdata;
              state  <= HOLD;
              req    <= 1'b0;
            end else pcf <= pc_plus4;
          end else if (redir) begin
            // Request in flight: address must stay put, so park the target.
            redir_pc <= target;
            state    <= DROP;
          end
        end
        DROP: begin
          if (redir) redir_pc <= target;
          if (imem.ImemReady) begin
            pcf   <= redir ? target : redir_pc;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redir) begin
            pcf   <= target;
            state <= FETCH;
            req   <= 1'b1;
          end else if (!StallF) begin
            pcf   <= pc_plus4;
            state <= FETCH;
            req   <= 1'b1;
          end
        end
        default: begin
          state <= FETCH;
          req   <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg #(.T(ifid_t), .BUBBLE(BUBBLE_V)) u_ifid (
    .clk    (clk),
    .rst    (reset),
    .en     (~StallD),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCPlus4D = ifid_q.pc_plus4;
  assign ValidD   = ifid_q.valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus a hand-written
// reset-during-DROP sequence. Memory returns addr ^ A500_0000 as the instruction.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0;
  logic [31:0] PCBranchD = '0;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD;
  int          nvec = 0, nmis = 0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .imem      (imem),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  assign imem.ImemRdata = mem(imem.ImemAddr);

  typedef struct {
    logic        rdy, sf, sd, ps;
    logic [31:0] br;
    logic [31:0] addr;   // expected before the edge
    logic        req;
    logic [31:0] instr;  // expected after the edge
    logic [31:0] pc4;
    logic        valid;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rdy, sf, sd, ps, input logic [31:0] br, addr,
                     input logic req, input logic [31:0] instr, pc4, input logic valid);
    vec_t v;
    v = '{rdy: rdy, sf: sf, sd: sd, ps: ps, br: br, addr: addr, req: req,
          instr: instr, pc4: pc4, valid: valid};
    tv.push_back(v);
  endtask

  // Shorthand: real instruction from address a, or a bubble.
  task automatic real_v(input logic rdy, sf, sd, ps, input logic [31:0] br, addr, a);
    add(rdy, sf, sd, ps, br, addr, 1'b1, mem(a), a + 32'd4, 1'b1);
  endtask
  task automatic bub_v(input logic rdy, sf, sd, ps, input logic [31:0] br, addr);
    add(rdy, sf, sd, ps, br, addr, 1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // normal stream 0,4,8,C
    real_v(1,0,0,0, 0, 32'h00, 32'h00);
    real_v(1,0,0,0, 0, 32'h04, 32'h04);
    real_v(1,0,0,0, 0, 32'h08, 32'h08);
    real_v(1,0,0,0, 0, 32'h0C, 32'h0C);
    // three wait cycles at 0x10
    bub_v (0,0,0,0, 0, 32'h10);
    bub_v (0,0,0,0, 0, 32'h10);
    bub_v (0,0,0,0, 0, 32'h10);
    real_v(1,0,0,0, 0, 32'h10, 32'h10);
    // redirect with misaligned target, low bits forced to 0 -> 0x1C
    bub_v (1,0,0,1, 32'h1F, 32'h14);
    real_v(1,0,0,0, 0, 32'h1C, 32'h1C);
    // stall at 0x20: fetch completes into HOLD, IF/ID held
    add   (1,1,1,0, 0, 32'h20, 1'b1, mem(32'h1C), 32'h20, 1'b1);
    add   (1,1,1,0, 0, 32'h20, 1'b0, mem(32'h1C), 32'h20, 1'b1);
    add   (0,0,0,0, 0, 32'h20, 1'b0, mem(32'h20), 32'h24, 1'b1);
    real_v(1,0,0,0, 0, 32'h24, 32'h24);
    // taken branch with ready=1 at 0x40
    bub_v (1,0,0,1, 32'h40, 32'h28);
    bub_v (1,0,0,1, 32'h100, 32'h40);
    real_v(1,0,0,0, 0, 32'h100, 32'h100);
    // branch while 0x50 pending -> DROP
    bub_v (1,0,0,1, 32'h50, 32'h104);
    bub_v (0,0,0,1, 32'h200, 32'h50);
    bub_v (0,0,0,0, 0, 32'h50);
    bub_v (1,0,0,0, 0, 32'h50);
    real_v(1,0,0,0, 0, 32'h200, 32'h200);
    // second redirect inside DROP wins
    bub_v (0,0,0,1, 32'h60, 32'h204);
    bub_v (0,0,0,1, 32'h70, 32'h204);
    bub_v (1,0,0,0, 0, 32'h204);
    real_v(1,0,0,0, 0, 32'h70, 32'h70);
    // PC wrap
    bub_v (1,0,0,1, 32'hFFFF_FFFC, 32'h74);
    real_v(1,0,0,0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    real_v(1,0,0,0, 0, 32'h00, 32'h00);
    // PCSrcD ignored under StallD
    add   (0,1,1,1, 32'h500, 32'h04, 1'b1, mem(32'h00), 32'h04, 1'b1);
    real_v(1,0,0,0, 0, 32'h04, 32'h04);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset addr",  imem.ImemAddr, 32'h0);
    chk("reset req",   {31'b0, imem.ImemReq}, 32'h1);
    chk("reset instr", InstrD, 32'h0);
    chk("reset pc4",   PCPlus4D, 32'h0);
    chk("reset valid", {31'b0, ValidD}, 32'h0);
    reset = 1'b0;

    foreach (tv[i]) begin
      imem.ImemReady = tv[i].rdy;
      StallF = tv[i].sf; StallD = tv[i].sd;
      PCSrcD = tv[i].ps; PCBranchD = tv[i].br;
      #1;
      chk($sformatf("row%0d addr", i), imem.ImemAddr, tv[i].addr);
      chk($sformatf("row%0d req", i),  {31'b0, imem.ImemReq}, {31'b0, tv[i].req});
      @(posedge clk); #1;
      chk($sformatf("row%0d instr", i), InstrD, tv[i].instr);
      chk($sformatf("row%0d pc4", i),   PCPlus4D, tv[i].pc4);
      chk($sformatf("row%0d valid", i), {31'b0, ValidD}, {31'b0, tv[i].valid});
    end

    // reset while in DROP: PCF is 0x08 here
    imem.ImemReady = 1'b0; StallF = 1'b0; StallD = 1'b0;
    PCSrcD = 1'b1; PCBranchD = 32'h80;
    @(posedge clk); #1;
    PCSrcD = 1'b0;
    chk("drop addr", imem.ImemAddr, 32'h08);
    #2 reset = 1'b1;
    #1;
    chk("async rst addr",  imem.ImemAddr, 32'h0);
    chk("async rst req",   {31'b0, imem.ImemReq}, 32'h1);
    chk("async rst valid", {31'b0, ValidD}, 32'h0);
    chk("async rst pc4",   PCPlus4D, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post rst addr", imem.ImemAddr, 32'h0);
    imem.ImemReady = 1'b1;
    @(posedge clk); #1;
    chk("post rst instr", InstrD, mem(32'h0));
    chk("post rst pc4",   PCPlus4D, 32'h4);
    chk("post rst valid", {31'b0, ValidD}, 32'h1);
    chk("post rst next",  imem.ImemAddr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
